// File: rtl/hgcal_input_quantizer_if.sv
// rtl/hgcal_input_quantizer_if.sv - sample-in / packed-vector-out handshake bundle
//
// Purpose: groups the serial sample stream, the packed output vector and
//          the framing-error pulse of hgcal_input_quantizer.
// Signals:
//   in_valid/in_ready/in_data/in_last  serial signed sample stream
//   out_valid/out_ready/out_data       packed quantized vector
//   frame_err                          one-cycle framing violation pulse
// Modports: master = sample source / vector sink, slave = quantizer.
interface hgcal_input_quantizer_if #(
  parameter int NUM_FEAT = 4,
  parameter int IN_W     = 16,
  parameter int OUT_BW   = 2
);
  logic                       in_valid;
  logic                       in_ready;
  logic [IN_W-1:0]            in_data;
  logic                       in_last;
  logic                       out_valid;
  logic                       out_ready;
  logic [NUM_FEAT*OUT_BW-1:0] out_data;
  logic                       frame_err;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, frame_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, frame_err
  );
endinterface

// File: rtl/hgcal_input_quantizer.sv
// rtl/hgcal_input_quantizer.sv - quantize and pack serial samples for the first LUT layer
//
// Purpose: quantizes each signed sample to OUT_BW unsigned bits and packs
//          NUM_FEAT of them (feature 0 in the LSBs) into one output vector
//          held in a valid/ready register. A shadow register lets a full
//          frame wait while the output register is stalled.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    hgcal_input_quantizer_if.slave (sample stream, packed vector,
//          frame_err pulse)
// Build option: QUANT_ROUND_EN selects round-half-up before the shift;
//               undefined gives a truncating shift.
module hgcal_input_quantizer #(
  parameter int NUM_FEAT = 4,
  parameter int IN_W     = 16,
  parameter int OUT_BW   = 2,
  parameter int SHIFT    = 4,
  parameter int OFFSET   = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  hgcal_input_quantizer_if.slave bus
);

  localparam int VEC_W = NUM_FEAT * OUT_BW;
  localparam int CNT_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(NUM_FEAT - 1);
  localparam logic signed [IN_W:0] OFF_S    = (IN_W+1)'(OFFSET);
  localparam logic signed [IN_W:0] MAX_Q    = (IN_W+1)'((1 << OUT_BW) - 1);

  typedef enum logic {S_FILL = 1'b0, S_STALL = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [VEC_W-1:0]      r_shadow;
  logic [VEC_W-1:0]      r_out_data;
  logic                  r_out_valid;
  logic                  r_frame_err;

  logic signed [IN_W:0]  w_ext;
  logic signed [IN_W:0]  w_pre;
  logic signed [IN_W:0]  w_t;
  logic [OUT_BW-1:0]     w_q;
  logic [VEC_W-1:0]      w_full;
  logic                  w_in_ready;
  logic                  w_in_xfer;
  logic                  w_out_xfer;
  logic                  w_last_slot;

  // Sign-extend by one bit so the rounding add and offset cannot overflow.
  assign w_ext = {bus.in_data[IN_W-1], bus.in_data};

`ifdef QUANT_ROUND_EN
  localparam logic signed [IN_W:0] RND = (IN_W+1)'(1) << (SHIFT - 1);
  assign w_pre = w_ext + RND;
`else
  assign w_pre = w_ext;
`endif

  assign w_t = (w_pre >>> SHIFT) + OFF_S;

  always_comb begin
    w_q = '0;
    if (w_t[IN_W]) begin
      w_q = '0;
    end else if (w_t > MAX_Q) begin
      w_q = MAX_Q[OUT_BW-1:0];
    end else begin
      w_q = w_t[OUT_BW-1:0];
    end
  end

  // Completed vector: previously collected slots plus the final sample.
  always_comb begin
    w_full = r_shadow;
    w_full[(NUM_FEAT-1)*OUT_BW +: OUT_BW] = w_q;
  end

  assign w_in_xfer   = bus.in_valid && w_in_ready;
  assign w_out_xfer  = r_out_valid && bus.out_ready;
  assign w_last_slot = (r_cnt == LAST_CNT);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL: begin
        if (w_in_xfer && w_last_slot && r_out_valid && !bus.out_ready) begin
          w_state_nxt = S_STALL;
        end
      end
      S_STALL: begin
        if (w_out_xfer) begin
          w_state_nxt = S_FILL;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  // FSM: outputs (in_ready depends on state only, never on out_ready)
  always_comb begin
    w_in_ready = (r_state == S_FILL);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_shadow    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      // Default drop on consumption; a same-cycle load below re-asserts it.
      if (w_out_xfer) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        S_FILL: begin
          if (w_in_xfer) begin
            if (!w_last_slot) begin
              if (bus.in_last) begin
                // Early last: drop the partial frame.
                r_frame_err <= 1'b1;
                r_cnt       <= '0;
              end else begin
                r_shadow[r_cnt*OUT_BW +: OUT_BW] <= w_q;
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end else begin
              // Missing last still emits; the counter resyncs either way.
              r_frame_err <= !bus.in_last;
              r_cnt       <= '0;
              if (!r_out_valid || bus.out_ready) begin
                r_out_data  <= w_full;
                r_out_valid <= 1'b1;
              end else begin
                r_shadow <= w_full;
              end
            end
          end
        end
        S_STALL: begin
          if (w_out_xfer) begin
            r_out_data  <= r_shadow;
            r_out_valid <= 1'b1;
            r_cnt       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_hgcal_input_quantizer.sv
// tb/tb_hgcal_input_quantizer.sv - scoreboard bench for hgcal_input_quantizer
module tb_hgcal_input_quantizer;
  localparam int NF = 4;
  localparam int IW = 16;
  localparam int OB = 2;
  localparam int VW = NF * OB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hgcal_input_quantizer_if #(.NUM_FEAT(NF), .IN_W(IW), .OUT_BW(OB)) bus ();

  hgcal_input_quantizer #(
    .NUM_FEAT(NF), .IN_W(IW), .OUT_BW(OB), .SHIFT(4), .OFFSET(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int exp_err = 0;
  int seen_err = 0;
  logic [VW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every out transfer, checks hold stability.
  logic          hold_v = 1'b0;
  logic [VW-1:0] hold_d = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v <= 1'b0;
    end else begin
      if (bus.frame_err) seen_err <= seen_err + 1;
      if (hold_v) chk("hold_stable", 32'(bus.out_data), 32'(hold_d));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_vector", 32'(bus.out_data), 32'hDEAD);
        end else begin
          chk("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        end
      end
      hold_v <= bus.out_valid && !bus.out_ready;
      hold_d <= bus.out_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one sample, starting at posedge+#1 and ending at the next posedge+#1.
  task automatic send(input logic [IW-1:0] d, input logic l);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("in_ready_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic frame(input logic [IW-1:0] d0, input logic [IW-1:0] d1,
                       input logic [IW-1:0] d2, input logic [IW-1:0] d3,
                       input logic l, input logic [VW-1:0] e);
    send(d0, 1'b0);
    send(d1, 1'b0);
    send(d2, 1'b0);
    exp_q.push_back(e);
    if (!l) exp_err++;
    send(d3, l);
  endtask

  logic [VW-1:0] round_exp;
  time t0;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
`ifdef QUANT_ROUND_EN
    round_exp = 8'b11011110;
`else
    round_exp = 8'b11011010;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
    @(posedge clk);
    #1;

    // Reset mid-frame, then a full frame packs from slot 0
    send(16'sd48, 1'b0);
    send(16'sd48, 1'b0);
    rst_n = 1'b0;
    #3;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    frame(16'sd0, 16'sd16, -16'sd32, 16'sd48, 1'b1, 8'b11001110);
    repeat (2) @(posedge clk);
    #1;

    // Quantize/pack with clamps, one-cycle latency
    frame(-16'sd32, 16'sd0, 16'sd16, 16'sd48, 1'b1, 8'b11111000);
    chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
    repeat (2) @(posedge clk);
    #1;

    // Rounding-sensitive samples
    frame(16'sd7, 16'sd8, -16'sd9, 16'sd24, 1'b1, round_exp);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: two frames while stalled
    bus.out_ready = 1'b0;
    frame(16'sd0, 16'sd16, -16'sd32, 16'sd48, 1'b1, 8'b11001110);
    frame(-16'sd32, 16'sd0, 16'sd16, 16'sd48, 1'b1, 8'b11111000);
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
    repeat (3) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("release_out_valid", 32'(bus.out_valid), 32'd1);
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back frames: 12 samples in 12 cycles
    t0 = $time;
    frame(-16'sd32, 16'sd0, 16'sd16, 16'sd48, 1'b1, 8'b11111000);
    frame(16'sd0, 16'sd16, -16'sd32, 16'sd48, 1'b1, 8'b11001110);
    frame(16'sd48, 16'sd48, -16'sd32, 16'sd0, 1'b1, 8'b10001111);
    chk("b2b_cycles", 32'(($time - t0) / 10), 32'd12);
    repeat (2) @(posedge clk);
    #1;

    // Framing case 1: early last drops the partial frame
    send(16'sd0, 1'b0);
    exp_err++;
    send(16'sd16, 1'b1);
    chk("early_last_err", 32'(bus.frame_err), 32'd1);
    chk("early_last_no_out", 32'(bus.out_valid), 32'd0);
    frame(16'sd16, 16'sd16, 16'sd16, 16'sd16, 1'b1, 8'b11111111);
    repeat (2) @(posedge clk);
    #1;

    // Framing case 2: missing last still emits
    frame(-16'sd32, 16'sd0, 16'sd16, 16'sd48, 1'b0, 8'b11111000);
    chk("missing_last_err", 32'(bus.frame_err), 32'd1);
    chk("missing_last_out", 32'(bus.out_valid), 32'd1);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("frame_err_pulses", 32'(seen_err), 32'(exp_err));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
